// File: rtl/sort_engine_v2.sv
// rtl/sort_engine_v2.sv - in-place bubble sort over a single-outstanding AXI-lite-style memory master
// Supports wrapped base addressing, asc/desc and signed/unsigned ordering, bus-error abort and a swap counter.
module sort_engine_v2 #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 2,
    parameter int CNT_WDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_WDTH:0]   arr_size,
    input  logic [ADDR_WDTH-1:0] base_addr,
    input  logic                 descending,
    input  logic                 signed_cmp,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [CNT_WDTH-1:0]  swap_count,
    input  logic                 ar_ready,
    output logic                 ar_valid,
    output logic [ADDR_WDTH-1:0] ar_address,
    input  logic                 r_valid,
    output logic                 r_ready,
    input  logic [DATA_WDTH-1:0] r_data,
    input  logic [RESP_WDTH-1:0] r_resp,
    input  logic                 aw_ready,
    output logic                 aw_valid,
    output logic [ADDR_WDTH-1:0] aw_address,
    input  logic                 w_ready,
    output logic                 w_valid,
    output logic [DATA_WDTH-1:0] w_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [RESP_WDTH-1:0] b_resp
);

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_CMP, S_W, S_B, S_DONE
    } state_t;

    localparam logic [ADDR_WDTH:0]   MAX_N = {1'b1, {ADDR_WDTH{1'b0}}};
    localparam logic [ADDR_WDTH-1:0] A_ONE = {{(ADDR_WDTH-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [ADDR_WDTH-1:0]   last_q, last_d;
    logic [ADDR_WDTH-1:0]   idx_q, idx_d;
    logic [ADDR_WDTH-1:0]   base_q, base_d;
    logic [ADDR_WDTH-1:0]   addr_q, addr_d;
    logic [DATA_WDTH-1:0]   cur_q, cur_d;
    logic [DATA_WDTH-1:0]   nxt_q, nxt_d;
    logic [DATA_WDTH-1:0]   wdata_q, wdata_d;
    logic                   desc_q, desc_d;
    logic                   sgn_q, sgn_d;
    logic                   swapped_q, swapped_d;
    logic                   rd_nxt_q, rd_nxt_d;
    logic                   wr_second_q, wr_second_d;
    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q, w_done_d;
    logic                   err_q, err_d;
    logic [1:0]             err_code_q, err_code_d;
    logic [CNT_WDTH-1:0]    swap_cnt_q, swap_cnt_d;

    logic                   cur_gt, cur_lt, out_of_order;
    logic [ADDR_WDTH-1:0]   idx_inc, last_dec;
    logic                   aw_hs, w_hs;

    state_t                 adv_state;
    logic [ADDR_WDTH-1:0]   adv_idx, adv_last, adv_addr;
    logic                   adv_swapped, adv_rd_nxt;

    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign swap_count = swap_cnt_q;
    assign ar_valid   = (state_q == S_AR);
    assign ar_address = addr_q;
    assign r_ready    = (state_q == S_R);
    assign aw_valid   = (state_q == S_W) && !aw_done_q;
    assign w_valid    = (state_q == S_W) && !w_done_q;
    assign aw_address = addr_q;
    assign w_data     = wdata_q;
    assign b_ready    = (state_q == S_B);

    assign aw_hs    = aw_valid && aw_ready;
    assign w_hs     = w_valid && w_ready;
    assign idx_inc  = idx_q + A_ONE;
    assign last_dec = last_q - A_ONE;

    always_comb begin
        cur_gt       = sgn_q ? ($signed(cur_q) > $signed(nxt_q)) : (cur_q > nxt_q);
        cur_lt       = sgn_q ? ($signed(cur_q) < $signed(nxt_q)) : (cur_q < nxt_q);
        out_of_order = desc_q ? cur_lt : cur_gt;
    end

    // Where to go after finishing step i: fetch element i+2, or close the pass.
    always_comb begin
        adv_state   = S_AR;
        adv_idx     = idx_inc;
        adv_last    = last_q;
        adv_swapped = swapped_q;
        adv_rd_nxt  = 1'b1;
        adv_addr    = base_q + idx_inc + A_ONE;
        if (!(idx_inc < last_q)) begin
            adv_last    = last_dec;
            adv_idx     = '0;
            adv_swapped = 1'b0;
            adv_rd_nxt  = 1'b0;
            adv_addr    = base_q;
            if (!swapped_q || (last_dec == '0)) begin
                adv_state = S_DONE;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        idx_d       = idx_q;
        base_d      = base_q;
        addr_d      = addr_q;
        cur_d       = cur_q;
        nxt_d       = nxt_q;
        wdata_d     = wdata_q;
        desc_d      = desc_q;
        sgn_d       = sgn_q;
        swapped_d   = swapped_q;
        rd_nxt_d    = rd_nxt_q;
        wr_second_d = wr_second_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        swap_cnt_d  = swap_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d     = base_addr;
                    desc_d     = descending;
                    sgn_d      = signed_cmp;
                    err_d      = 1'b0;
                    err_code_d = 2'd0;
                    swap_cnt_d = '0;
                    idx_d      = '0;
                    swapped_d  = 1'b0;
                    rd_nxt_d   = 1'b0;
                    addr_d     = base_addr;
                    last_d     = arr_size[ADDR_WDTH-1:0] - A_ONE;
                    if (arr_size > MAX_N) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd1;
                        state_d    = S_DONE;
                    end else if (arr_size[ADDR_WDTH:1] == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_AR;
                    end
                end
            end
            S_AR: begin
                if (ar_ready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (r_valid) begin
                    if (r_resp != '0) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd2;
                        state_d    = S_DONE;
                    end else if (!rd_nxt_q) begin
                        cur_d    = r_data;
                        rd_nxt_d = 1'b1;
                        addr_d   = base_q + idx_q + A_ONE;
                        state_d  = S_AR;
                    end else begin
                        nxt_d   = r_data;
                        state_d = S_CMP;
                    end
                end
            end
            S_CMP: begin
                if (out_of_order) begin
                    swapped_d   = 1'b1;
                    if (swap_cnt_q != {CNT_WDTH{1'b1}}) begin
                        swap_cnt_d = swap_cnt_q + 1'b1;
                    end
                    addr_d      = base_q + idx_q;
                    wdata_d     = nxt_q;
                    wr_second_d = 1'b0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    state_d     = S_W;
                end else begin
                    cur_d     = nxt_q;
                    state_d   = adv_state;
                    idx_d     = adv_idx;
                    last_d    = adv_last;
                    swapped_d = adv_swapped;
                    rd_nxt_d  = adv_rd_nxt;
                    addr_d    = adv_addr;
                end
            end
            S_W: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = S_B;
                end
            end
            S_B: begin
                if (b_valid) begin
                    if (b_resp != '0) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd3;
                        state_d    = S_DONE;
                    end else if (!wr_second_q) begin
                        // cur stays the travelling element, so it lands one slot further on.
                        wr_second_d = 1'b1;
                        addr_d      = base_q + idx_q + A_ONE;
                        wdata_d     = cur_q;
                        aw_done_d   = 1'b0;
                        w_done_d    = 1'b0;
                        state_d     = S_W;
                    end else begin
                        state_d   = adv_state;
                        idx_d     = adv_idx;
                        last_d    = adv_last;
                        swapped_d = adv_swapped;
                        rd_nxt_d  = adv_rd_nxt;
                        addr_d    = adv_addr;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= '0;
            idx_q       <= '0;
            base_q      <= '0;
            addr_q      <= '0;
            cur_q       <= '0;
            nxt_q       <= '0;
            wdata_q     <= '0;
            desc_q      <= 1'b0;
            sgn_q       <= 1'b0;
            swapped_q   <= 1'b0;
            rd_nxt_q    <= 1'b0;
            wr_second_q <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
            swap_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            addr_q      <= addr_d;
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            wdata_q     <= wdata_d;
            desc_q      <= desc_d;
            sgn_q       <= sgn_d;
            swapped_q   <= swapped_d;
            rd_nxt_q    <= rd_nxt_d;
            wr_second_q <= wr_second_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            swap_cnt_q  <= swap_cnt_d;
        end
    end

endmodule

// File: tb/tb_sort_engine_v2.sv
// tb/tb_sort_engine_v2.sv - directed self-checking bench for sort_engine_v2 with a reactive memory slave
module tb_sort_engine_v2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  arr_size;
    logic [3:0]  base_addr;
    logic        descending, signed_cmp;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [15:0] swap_count;
    logic        ar_ready, ar_valid;
    logic [3:0]  ar_address;
    logic        r_valid, r_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        aw_ready, aw_valid;
    logic [3:0]  aw_address;
    logic        w_ready, w_valid;
    logic [31:0] w_data;
    logic        b_valid, b_ready;
    logic [1:0]  b_resp;

    sort_engine_v2 #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(2), .CNT_WDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .arr_size(arr_size), .base_addr(base_addr),
        .descending(descending), .signed_cmp(signed_cmp), .busy(busy), .done(done),
        .err(err), .err_code(err_code), .swap_count(swap_count),
        .ar_ready(ar_ready), .ar_valid(ar_valid), .ar_address(ar_address),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .aw_ready(aw_ready), .aw_valid(aw_valid), .aw_address(aw_address),
        .w_ready(w_ready), .w_valid(w_valid), .w_data(w_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [16];
    logic [15:0] touched;
    int total = 0, bad = 0;
    int rd_cnt, wr_cnt, done_cnt, proto_err, split_cnt, valid_seen;
    int ar_wait, aw_wait, w_wait;
    bit bp_en = 0, inj_b = 0, inj_r = 0;
    bit r_pend, b_pend, aw_got, w_got, ar_held, aw_held, w_held, aw_fire, w_fire;
    logic [3:0]  r_addr, wr_addr, ar_haddr, aw_haddr;
    logic [31:0] wr_data, w_hdata;

    // Memory slave: all decisions at the falling edge, so handshakes land on the next rising edge.
    initial begin
        ar_ready = 0; r_valid = 0; r_data = 0; r_resp = 0;
        aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ar_ready = 0; r_valid = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
                r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
                ar_held = 0; aw_held = 0; w_held = 0;
            end else begin
                if (done) done_cnt++;
                if (ar_valid || aw_valid || w_valid) valid_seen++;
                if (ar_held && (!ar_valid || ar_address != ar_haddr)) proto_err++;
                if (aw_held && (!aw_valid || aw_address != aw_haddr)) proto_err++;
                if (w_held && (!w_valid || w_data != w_hdata)) proto_err++;

                ar_ready = 0;
                if (ar_valid) begin
                    if (ar_wait > 0) ar_wait--; else ar_ready = 1;
                end
                ar_held = ar_valid && !ar_ready;
                ar_haddr = ar_address;
                if (ar_valid && ar_ready) begin
                    rd_cnt++;
                    touched[ar_address] = 1'b1;
                    r_pend = 1; r_addr = ar_address;
                    ar_wait = bp_en ? int'($urandom_range(0, 5)) : 0;
                end

                r_valid = 0;
                if (r_pend && r_ready) begin
                    r_valid = 1; r_data = mem[r_addr];
                    r_resp = inj_r ? 2'd2 : 2'd0;
                    inj_r = 0; r_pend = 0;
                end

                aw_ready = 0;
                if (aw_valid) begin
                    if (aw_wait > 0) aw_wait--; else aw_ready = 1;
                end
                w_ready = 0;
                if (w_valid) begin
                    if (w_wait > 0) w_wait--; else w_ready = 1;
                end
                aw_held = aw_valid && !aw_ready; aw_haddr = aw_address;
                w_held  = w_valid && !w_ready;   w_hdata  = w_data;
                aw_fire = aw_valid && aw_ready;
                w_fire  = w_valid && w_ready;
                if (aw_fire) begin aw_got = 1; wr_addr = aw_address; end
                if (w_fire)  begin w_got = 1;  wr_data = w_data; end
                if (aw_fire != w_fire) split_cnt++;
                if (aw_got && w_got) begin
                    mem[wr_addr] = wr_data;
                    touched[wr_addr] = 1'b1;
                    wr_cnt++;
                    aw_got = 0; w_got = 0; b_pend = 1;
                    aw_wait = bp_en ? int'($urandom_range(0, 5)) : 0;
                    w_wait  = bp_en ? (aw_wait + 1 + int'($urandom_range(0, 3))) % 6 : 0;
                end

                b_valid = 0;
                if (b_pend && b_ready) begin
                    b_valid = 1;
                    b_resp = inj_b ? 2'd2 : 2'd0;
                    inj_b = 0; b_pend = 0;
                end
            end
        end
    end

    task automatic clear_stats();
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; proto_err = 0; split_cnt = 0; valid_seen = 0;
        touched = '0;
        ar_wait = 0; aw_wait = 0; w_wait = 0;
        for (int k = 0; k < 16; k++) mem[k] = 32'hDEAD_0000 + k;
    endtask

    task automatic run_sort(input int n, input int base, input bit desc, input bit sgn,
                            output int lat, output bit tmo, output bit first_busy, output bit first_err);
        @(negedge clk);
        arr_size = 5'(n); base_addr = 4'(base); descending = desc; signed_cmp = sgn; start = 1;
        @(negedge clk);
        start = 0;
        first_busy = busy; first_err = err;
        lat = 1; tmo = 1;
        for (int c = 0; c < 3000; c++) begin
            if (done) begin tmo = 0; break; end
            @(negedge clk);
            lat++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; start = 0; arr_size = 0; base_addr = 0; descending = 0; signed_cmp = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, err, err_code, ar_valid, r_ready, aw_valid, w_valid, b_ready} !== 10'd0) begin
            bad++; $display("FAIL reset_outputs: got %b want 0", {busy, done, err, err_code, ar_valid, r_ready, aw_valid, w_valid, b_ready});
        end
        total++;
        if (swap_count !== 16'd0) begin bad++; $display("FAIL reset_swap_count: got %0d want 0", swap_count); end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_ascending();
        int lat; bit tmo, fb, fe;
        logic [31:0] exp_v [4];
        exp_v = '{32'd1, 32'd2, 32'd3, 32'd4};
        clear_stats();
        mem[0] = 3; mem[1] = 1; mem[2] = 4; mem[3] = 2;
        run_sort(4, 0, 0, 0, lat, tmo, fb, fe);
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL asc_timeout: got %0d want 0", tmo); end
        total++; if (fb !== 1'b1) begin bad++; $display("FAIL asc_busy_after_start: got %0d want 1", fb); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (mem[k] !== exp_v[k]) begin bad++; $display("FAIL asc_mem[%0d]: got %0d want %0d", k, mem[k], exp_v[k]); end
        end
        total++; if (swap_count !== 16'd3) begin bad++; $display("FAIL asc_swaps: got %0d want 3", swap_count); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL asc_done_pulses: got %0d want 1", done_cnt); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL asc_err: got %0d want 0", err); end
    endtask

    task automatic test_descending_wrap();
        int lat; bit tmo, fb, fe;
        clear_stats();
        mem[14] = 32'hFFFF_FFFF; mem[15] = 32'd5; mem[0] = 32'hFFFF_FFF8; mem[1] = 32'd0;
        run_sort(4, 14, 1, 1, lat, tmo, fb, fe);
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL desc_timeout: got %0d want 0", tmo); end
        total++;
        if ({mem[14], mem[15], mem[0], mem[1]} !== {32'd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF8}) begin
            bad++; $display("FAIL desc_mem: got %h %h %h %h want 5 0 -1 -8", mem[14], mem[15], mem[0], mem[1]);
        end
        total++; if (touched !== 16'hC003) begin bad++; $display("FAIL desc_addr_set: got %h want c003", touched); end
        total++; if (swap_count !== 16'd3) begin bad++; $display("FAIL desc_swaps: got %0d want 3", swap_count); end
    endtask

    task automatic test_sorted();
        int lat; bit tmo, fb, fe;
        clear_stats();
        for (int k = 0; k < 8; k++) mem[k] = 32'(10 * (k + 1));
        run_sort(8, 0, 0, 0, lat, tmo, fb, fe);
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL sorted_timeout: got %0d want 0", tmo); end
        total++; if (rd_cnt !== 8) begin bad++; $display("FAIL sorted_reads: got %0d want 8", rd_cnt); end
        total++; if (wr_cnt !== 0) begin bad++; $display("FAIL sorted_writes: got %0d want 0", wr_cnt); end
        total++; if (swap_count !== 16'd0) begin bad++; $display("FAIL sorted_swaps: got %0d want 0", swap_count); end
    endtask

    task automatic test_size();
        int lat; bit tmo, fb, fe;
        clear_stats();
        run_sort(1, 3, 0, 0, lat, tmo, fb, fe);
        total++; if (tmo !== 1'b0 || lat > 2) begin bad++; $display("FAIL n1_latency: got %0d (timeout %0d) want <=2", lat, tmo); end
        total++; if (valid_seen !== 0 || rd_cnt !== 0) begin bad++; $display("FAIL n1_bus: got %0d valid cycles want 0", valid_seen); end
        total++; if (err !== 1'b0 || done_cnt !== 1) begin bad++; $display("FAIL n1_status: got err=%0d done=%0d want 0 1", err, done_cnt); end
        clear_stats();
        run_sort(0, 0, 0, 0, lat, tmo, fb, fe);
        total++; if (tmo !== 1'b0 || err !== 1'b0 || valid_seen !== 0) begin bad++; $display("FAIL n0: got tmo=%0d err=%0d valids=%0d want 0 0 0", tmo, err, valid_seen); end
        clear_stats();
        run_sort(17, 0, 0, 0, lat, tmo, fb, fe);
        total++; if (err !== 1'b1 || err_code !== 2'd1) begin bad++; $display("FAIL n17_err: got err=%0d code=%0d want 1 1", err, err_code); end
        total++; if (valid_seen !== 0 || done_cnt !== 1) begin bad++; $display("FAIL n17_bus: got valids=%0d done=%0d want 0 1", valid_seen, done_cnt); end
    endtask

    task automatic test_back_pressure();
        int lat; bit tmo, fb, fe;
        clear_stats();
        bp_en = 1;
        ar_wait = 3; aw_wait = 2; w_wait = 5;
        mem[5] = 2; mem[6] = 1;
        run_sort(2, 5, 0, 0, lat, tmo, fb, fe);
        bp_en = 0;
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL bp_timeout: got %0d want 0", tmo); end
        total++; if (mem[5] !== 32'd1 || mem[6] !== 32'd2) begin bad++; $display("FAIL bp_mem: got %0d %0d want 1 2", mem[5], mem[6]); end
        total++; if (proto_err !== 0) begin bad++; $display("FAIL bp_valid_stable: got %0d violations want 0", proto_err); end
        total++; if (split_cnt == 0) begin bad++; $display("FAIL bp_split_handshake: got %0d want >0", split_cnt); end
        total++; if (done_cnt !== 1 || swap_count !== 16'd1) begin bad++; $display("FAIL bp_status: got done=%0d swaps=%0d want 1 1", done_cnt, swap_count); end
    endtask

    task automatic test_bus_error();
        int lat; bit tmo, fb, fe;
        clear_stats();
        mem[0] = 9; mem[1] = 3; inj_b = 1;
        run_sort(2, 0, 0, 0, lat, tmo, fb, fe);
        total++; if (tmo !== 1'b0 || done_cnt !== 1) begin bad++; $display("FAIL berr_done: got tmo=%0d done=%0d want 0 1", tmo, done_cnt); end
        total++; if (err !== 1'b1 || err_code !== 2'd3) begin bad++; $display("FAIL berr_code: got err=%0d code=%0d want 1 3", err, err_code); end
        total++; if (wr_cnt !== 1) begin bad++; $display("FAIL berr_writes: got %0d want 1", wr_cnt); end
        clear_stats();
        mem[0] = 7; mem[1] = 6; inj_r = 1;
        run_sort(2, 0, 0, 0, lat, tmo, fb, fe);
        total++; if (err_code !== 2'd2 || rd_cnt !== 1 || wr_cnt !== 0) begin bad++; $display("FAIL rerr: got code=%0d reads=%0d writes=%0d want 2 1 0", err_code, rd_cnt, wr_cnt); end
        clear_stats();
        mem[0] = 2; mem[1] = 1;
        run_sort(2, 0, 0, 0, lat, tmo, fb, fe);
        total++; if (fe !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL err_clear: got %0d/%0d want 0", fe, err); end
        total++; if (mem[0] !== 32'd1 || mem[1] !== 32'd2) begin bad++; $display("FAIL err_rerun_mem: got %0d %0d want 1 2", mem[0], mem[1]); end
    endtask

    task automatic test_reset_mid_run();
        clear_stats();
        bp_en = 1; ar_wait = 2;
        mem[0] = 4; mem[1] = 3; mem[2] = 2; mem[3] = 1;
        @(negedge clk);
        arr_size = 5'd4; base_addr = 4'd0; descending = 0; signed_cmp = 0; start = 1;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        rst = 1;
        #1;
        total++;
        if ({ar_valid, aw_valid, w_valid, busy, done} !== 5'd0) begin
            bad++; $display("FAIL midrst_outputs: got %b want 0", {ar_valid, aw_valid, w_valid, busy, done});
        end
        repeat (2) @(negedge clk);
        rst = 0; bp_en = 0;
        repeat (3) @(negedge clk);
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL midrst_no_done: got %0d want 0", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_descending_wrap();
        test_sorted();
        test_size();
        test_back_pressure();
        test_bus_error();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sort_engine_v2.md
Name: sort_engine_v2

Overview:
- Parametrised successor of the team's in-memory sort block.
- Sorts `arr_size` words in place in a memory reached through a single-outstanding AXI-lite-style master (AR/R/AW/W/B channels). Uses bubble sort with early exit.
- Adds a programmable base address with address wrap, ascending/descending and signed/unsigned modes, bus-error abort with an error code, and a swap counter.
- Sits between the control/register block and the shared memory port.

Parameters:
- ADDR_WDTH, 4, word-address width; maximum array length is 2^ADDR_WDTH.
- DATA_WDTH, 32, element width.
- RESP_WDTH, 2, response width; 0 = OKAY, any nonzero value = error.
- CNT_WDTH, 16, width of `swap_count`; saturates at all-ones.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin sort; sampled only in IDLE.
- arr_size  in  ADDR_WDTH+1  number of elements, latched at start.
- base_addr  in  ADDR_WDTH  word address of element 0, latched at start.
- descending  in  1  1 = largest first; latched at start.
- signed_cmp  in  1  1 = two's-complement compare; latched at start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at completion, whether successful or aborted.
- err  out  1  sticky; cleared on the next accepted start.
- err_code  out  2  0 none, 1 size error, 2 read response error, 3 write response error.
- swap_count  out  CNT_WDTH  swaps performed in the current or last run.
- ar_ready  in  1;  ar_valid  out  1;  ar_address  out  ADDR_WDTH.
- r_valid  in  1;  r_ready  out  1;  r_data  in  DATA_WDTH;  r_resp  in  RESP_WDTH.
- aw_ready  in  1;  aw_valid  out  1;  aw_address  out  ADDR_WDTH.
- w_ready  in  1;  w_valid  out  1;  w_data  out  DATA_WDTH.
- b_valid  in  1;  b_ready  out  1;  b_resp  in  RESP_WDTH.

Behaviour:
- Reset (async, active-high): every output goes to 0, the FSM goes to IDLE, and all counters clear.
- Start: accepted only in IDLE when start=1. It latches the mode inputs, clears err, err_code and swap_count, and sets busy the next cycle. start while busy is ignored.
- Size check:
  - arr_size > 2^ADDR_WDTH: err=1, err_code=1, done pulse, no bus traffic.
  - arr_size is 0 or 1: done pulse with no bus traffic and no error.
- Address rule: element i lives at (base_addr + i) mod 2^ADDR_WDTH, so accesses wrap.
- Compare rule: a pair (cur at i, nxt at i+1) is out of order when
  - ascending: cur > nxt;
  - descending: cur < nxt;
  - signedness taken from the latched signed_cmp; equal values never swap.
- FSM states: IDLE, AR, R, CMP, W, B, DONE.
- Pass structure:
  - `last` = n-1 at start; the pass index i runs from 0 while i < last.
  - Pass start: read element 0 into cur (AR then R).
  - Each step: read element i+1 into nxt, then go to CMP (one cycle).
  - No swap: cur <= nxt, i++.
  - Swap: two write transactions, first nxt to address i, then cur to address i+1. cur is kept, swapped=1, swap_count++ (saturating), i++.
- End of pass: last-- (the largest/smallest element is now final).
  - If swapped=0 or last=0, go to DONE.
  - Otherwise clear swapped and begin the next pass.
- AR handshake: ar_valid asserts on entry to AR with ar_address stable, and holds until ar_ready (the same-cycle handshake counts). Then go to R.
- R handshake: r_ready=1 only in R; data is captured on r_valid. A nonzero r_resp aborts with err_code=2 and the data is discarded.
- W handshake: aw_valid and w_valid assert together. Each drops independently after its own handshake, and the FSM leaves W once both have completed, in either order or in the same cycle.
- B handshake: b_ready=1 only in B; completes on b_valid. A nonzero b_resp aborts with err_code=3; a second write is never issued after an error.
- Abort: the current handshake completes normally, then the FSM goes straight to DONE. It never leaves a valid asserted without a handshake. Memory may be partially sorted.
- DONE: one cycle; done=1, busy=0, then IDLE. start in the DONE cycle is ignored.
- Protocol limits: at most one outstanding transaction. Valids never drop before their ready, and the payload is unchanged while valid is held.
- Reset mid-run: immediate return to IDLE, all valids drop asynchronously, and no done pulse is generated.

Test Plan:
- Ascending, unsigned, base 0, n=4, mem {3,1,4,2} -> mem {1,2,3,4}, swap_count=3, single done pulse, err=0.
- Descending, signed, base 14, n=4, mem[14,15,0,1]={-1,5,-8,0} -> mem[14,15,0,1]={5,0,-1,-8}. Addresses must wrap 15->0; no access outside 14,15,0,1.
- Already sorted, n=8 -> exactly 8 reads, 0 writes, swap_count=0 (early exit after one pass).
- n=1 -> done pulse within 2 cycles of start, no valid asserted. n=17 with ADDR_WDTH=4 -> err=1, err_code=1, no bus activity.
- Random ready/valid back-pressure (ar/aw/w ready delayed 0-5 cycles, aw and w handshakes in different cycles) on {2,1} -> mem {1,2}. Valids held stable until their handshake.
- Inject b_resp=2 on the first write of {9,3} -> err_code=3, no second write, done pulse; the next start clears err.
